// File: rtl/dist_arbiter_pkg.sv
// Shared types for the dist_calc arbiter: number format, matrix layout,
// FSM state encoding and the watchdog width helper.
package dist_arbiter_pkg;

   localparam int NUMBER_BITS = 16;
   localparam int REAL        = 0;
   localparam int IMAG        = 1;
   localparam int DIST2_BITS  = 2 * (NUMBER_BITS + 3) + 1;

   // 2x2 complex matrix: [row][col][REAL/IMAG][bits]
   typedef logic [1:0][1:0][IMAG:REAL][NUMBER_BITS-1:0] mtx_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      RESPOND   = 3'd4
   } dist_arb_state_t;

   // Index offs positions after base, wrapping at n (base < n, offs < n).
   function automatic int wrap_idx(input int base, input int offs, input int n);
      int s;
      s = base + offs;
      return (s >= n) ? s - n : s;
   endfunction

   // Watchdog counter width: wide enough for the limit, clamped to 8..16 bits.
   function automatic int wd_width(input int limit);
      int w;
      w = $clog2(limit + 1);
      if (w < 8) begin
         w = 8;
      end else if (w > 16) begin
         w = 16;
      end
      return w;
   endfunction

endpackage

// File: rtl/dist_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
   import dist_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               any,
   output logic [NUM_REQ-1:0] sel,
   output logic [ID_W-1:0]    id
);

   logic [ID_W-1:0] cand [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = ID_W'(wrap_idx(int'(rr_ptr), gi, NUM_REQ));
   end

   // Scan from farthest to nearest so the candidate closest to rr_ptr wins.
   always_comb begin
      any = 1'b0;
      id  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            any = 1'b1;
            id  = cand[k];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign sel[gi] = any && (id == ID_W'(gi));
   end

endmodule

// File: rtl/dist_arbiter.sv
// Round-robin arbiter/sequencer sharing one dist_calc between NUM_REQ lanes.
// Optional watchdog on the wait states is enabled by DIST_ARB_TIMEOUT_EN.
module dist_arbiter
   import dist_arbiter_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int ID_W           = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  mtx_t                  req_mtx_a [NUM_REQ],
   input  mtx_t                  req_mtx_b [NUM_REQ],
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [DIST2_BITS-1:0] rsp_dist2,
   output logic                  rsp_err,
   output mtx_t                  calc_mtx_a,
   output mtx_t                  calc_mtx_b,
   output logic                  calc_ready,
   input  logic [DIST2_BITS-1:0] calc_dist2,
   input  logic                  calc_finished
);

   dist_arb_state_t state_reg, state_next;

   logic [ID_W-1:0]       rr_ptr_reg;
   logic [ID_W-1:0]       cur_id_reg;
   logic [NUM_REQ-1:0]    gnt_reg, gnt_next;
   logic                  calc_ready_reg, calc_ready_next;
   logic                  rsp_valid_reg, rsp_valid_next;
   logic [ID_W-1:0]       rsp_id_reg;
   logic [DIST2_BITS-1:0] rsp_dist2_reg;
   mtx_t                  calc_mtx_a_reg, calc_mtx_b_reg;

   logic                  pick_any;
   logic [NUM_REQ-1:0]    pick_sel;
   logic [ID_W-1:0]       pick_id;
   logic                  grant_fire;
   logic                  done_fire;
   logic                  wd_expired;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr_reg),
      .any    (pick_any),
      .sel    (pick_sel),
      .id     (pick_id)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Expiry is tested first so a timeout is never lost to the busy edge.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (pick_any && calc_finished) begin
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (wd_expired) begin
               state_next = RESPOND;
            end else if (!calc_finished) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (calc_finished || wd_expired) begin
               state_next = RESPOND;
            end
         end
         RESPOND: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      gnt_next        = '0;
      calc_ready_next = 1'b0;
      rsp_valid_next  = 1'b0;
      grant_fire      = 1'b0;
      done_fire       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_any && calc_finished) begin
               grant_fire = 1'b1;
               gnt_next   = pick_sel;
            end
         end
         LAUNCH: begin
            calc_ready_next = 1'b1;
         end
         WAIT_BUSY: begin
            rsp_valid_next = wd_expired;
         end
         WAIT_DONE: begin
            done_fire      = calc_finished;
            rsp_valid_next = calc_finished || wd_expired;
         end
         default: begin
         end
      endcase
   end

   // Operands only move on a grant: dist_calc reads them for its whole run.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_reg     <= '0;
         cur_id_reg     <= '0;
         gnt_reg        <= '0;
         calc_ready_reg <= 1'b0;
         rsp_valid_reg  <= 1'b0;
         rsp_id_reg     <= '0;
         rsp_dist2_reg  <= '0;
         calc_mtx_a_reg <= '0;
         calc_mtx_b_reg <= '0;
      end else begin
         gnt_reg        <= gnt_next;
         calc_ready_reg <= calc_ready_next;
         rsp_valid_reg  <= rsp_valid_next;
         if (grant_fire) begin
            cur_id_reg     <= pick_id;
            rr_ptr_reg     <= (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
            calc_mtx_a_reg <= req_mtx_a[pick_id];
            calc_mtx_b_reg <= req_mtx_b[pick_id];
         end
         if (done_fire) begin
            rsp_dist2_reg <= calc_dist2;
         end
         if (rsp_valid_next) begin
            rsp_id_reg <= cur_id_reg;
         end
      end
   end

`ifdef DIST_ARB_TIMEOUT_EN
   localparam int WD_W = wd_width(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_cnt_reg;
   logic            rsp_err_reg;
   logic            in_wait;

   assign in_wait    = (state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE);
   assign wd_expired = in_wait && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_cnt_reg <= '0;
      end else if (state_next == LAUNCH) begin
         wd_cnt_reg <= '0;
      end else if (in_wait) begin
         wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
   end

   // An error response keeps the previous rsp_dist2; only the flag changes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rsp_err_reg <= 1'b0;
      end else if (rsp_valid_next) begin
         rsp_err_reg <= !done_fire;
      end
   end

   assign rsp_err = rsp_err_reg;
`else
   assign wd_expired = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   assign gnt        = gnt_reg;
   assign calc_ready = calc_ready_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_id     = rsp_id_reg;
   assign rsp_dist2  = rsp_dist2_reg;
   assign calc_mtx_a = calc_mtx_a_reg;
   assign calc_mtx_b = calc_mtx_b_reg;

endmodule

// File: tb/tb_dist_arbiter.sv
// Self-checking bench for dist_arbiter with a dist_calc stub of programmable
// busy time and result; expectations come from a transaction-level model.
module tb_dist_arbiter;
   import dist_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int TO = 20;

   logic                  clk;
   logic                  reset;
   logic [N-1:0]          req;
   mtx_t                  req_mtx_a [N];
   mtx_t                  req_mtx_b [N];
   logic [N-1:0]          gnt;
   logic                  rsp_valid;
   logic [1:0]            rsp_id;
   logic [DIST2_BITS-1:0] rsp_dist2;
   logic                  rsp_err;
   mtx_t                  calc_mtx_a, calc_mtx_b;
   logic                  calc_ready;
   logic [DIST2_BITS-1:0] calc_dist2;
   logic                  calc_finished;

   // stub controls
   int                    stub_busy;
   logic [DIST2_BITS-1:0] stub_result;
   logic                  stub_hold;
   logic                  stub_never;
   int                    stub_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int model_ptr = 0;

   dist_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .req_mtx_a     (req_mtx_a),
      .req_mtx_b     (req_mtx_b),
      .gnt           (gnt),
      .rsp_valid     (rsp_valid),
      .rsp_id        (rsp_id),
      .rsp_dist2     (rsp_dist2),
      .rsp_err       (rsp_err),
      .calc_mtx_a    (calc_mtx_a),
      .calc_mtx_b    (calc_mtx_b),
      .calc_ready    (calc_ready),
      .calc_dist2    (calc_dist2),
      .calc_finished (calc_finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dist_calc stub: finished stays low for stub_busy cycles after a start
   always @(posedge clk) begin
      if (!reset) begin
         calc_finished <= 1'b1;
         calc_dist2    <= '0;
         stub_cnt      <= 0;
      end else if (stub_hold) begin
         calc_finished <= 1'b0;
         stub_cnt      <= 0;
      end else if (calc_ready) begin
         calc_finished <= 1'b0;
         stub_cnt      <= stub_busy;
      end else if (!calc_finished && !stub_never) begin
         if (stub_cnt <= 1) begin
            calc_finished <= 1'b1;
            calc_dist2    <= stub_result;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic mtx_t rand_mtx();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [DIST2_BITS-1:0] rand_d2();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[DIST2_BITS-1:0];
   endfunction

   // Round-robin rule: first requester at or after ptr, modulo N.
   function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic do_reset();
      reset      = 1'b0;
      req        = '0;
      stub_hold  = 1'b0;
      stub_never = 1'b0;
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_dist2", rsp_dist2, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_calc_ready", calc_ready, 0);
      check("rst_mtx_a", calc_mtx_a, 0);
      check("rst_mtx_b", calc_mtx_b, 0);
      @(negedge clk);
      reset     = 1'b1;
      model_ptr = 0;
   endtask

   // One full transaction from an IDLE arbiter. mode: 0 drop winner,
   // 1 hold all requests (reissue), 2 drop every request.
   task automatic serve(input int busy, input logic [DIST2_BITS-1:0] result, input int mode);
      int         w;
      int         lat;
      bit         seen;
      mtx_t       exp_a, exp_b;
      logic [N-1:0] exp_g;
      w = model_pick(req, model_ptr);
      if (w < 0) begin
         check("serve_has_req", 0, 1);
         return;
      end
      stub_busy   = busy;
      stub_result = result;
      exp_g       = N'(1) << w;
      @(negedge clk);
      check("gnt", gnt, exp_g);
      check("ready_early", calc_ready, 0);
      exp_a     = req_mtx_a[w];
      exp_b     = req_mtx_b[w];
      model_ptr = (w + 1) % N;
      if (mode == 0) req[w] = 1'b0;
      else if (mode == 2) req = '0;
      // operands change right after the grant; the latched copy must not
      req_mtx_a[w] = rand_mtx();
      req_mtx_b[w] = rand_mtx();
      @(negedge clk);
      check("calc_ready", calc_ready, 1);
      check("gnt_pulse", gnt, 0);
      lat  = 0;
      seen = 0;
      while (!seen && lat < busy + 20) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) seen = 1;
      end
      if (!seen) begin
         check("rsp_arrive", 0, 1);
         return;
      end
      check("rsp_lat", lat, busy + 2);
      check("rsp_id", rsp_id, w);
      check("rsp_dist2", rsp_dist2, result);
      check("rsp_err", rsp_err, 0);
      check("mtx_a_held", calc_mtx_a, exp_a);
      check("mtx_b_held", calc_mtx_b, exp_b);
      $display("txn: req %0d granted, busy %0d, rsp_id %0d, dist2 %0h", w, busy, rsp_id, rsp_dist2);
      @(negedge clk);
      check("rsp_pulse", rsp_valid, 0);
      check("rsp_dist2_hold", rsp_dist2, result);
   endtask

   initial begin
      int   bad;
      int   cnt;
      int   lat;
      logic err_seen;
      logic [DIST2_BITS-1:0] prev_d2;

      reset       = 1'b0;
      req         = '0;
      stub_hold   = 1'b0;
      stub_never  = 1'b0;
      stub_busy   = 1;
      stub_result = '0;
      for (int r = 0; r < N; r++) begin
         req_mtx_a[r] = rand_mtx();
         req_mtx_b[r] = rand_mtx();
      end
      do_reset();

      // single request from lane 2
      req[2] = 1'b1;
      serve(10, DIST2_BITS'(32'h1234), 0);

      // all lanes held high: round-robin order 0,1,2,3,0
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         serve(int'($urandom_range(1, 4)), rand_d2(), (k == 4) ? 2 : 1);
      end

      // no grant while dist_calc reports busy
      @(negedge clk);
      stub_hold = 1'b1;
      @(negedge clk);
      req[3] = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (gnt != 0) bad++;
      end
      check("gnt_blocked", bad, 0);
      stub_hold = 1'b0;
      @(negedge clk);
      check("gnt_blocked_edge", gnt, 0);
      serve(3, rand_d2(), 0);

      // randomized traffic
      for (int it = 0; it < 20; it++) begin
         for (int r = 0; r < N; r++) begin
            if (!req[r] && ($urandom_range(0, 1) == 1)) begin
               req[r]       = 1'b1;
               req_mtx_a[r] = rand_mtx();
               req_mtx_b[r] = rand_mtx();
            end
         end
         if (req == 0) req[$urandom_range(0, N - 1)] = 1'b1;
         serve(int'($urandom_range(1, 8)), rand_d2(), 0);
      end
      for (int g = 0; g < N && req != 0; g++) begin
         serve(int'($urandom_range(1, 8)), rand_d2(), 0);
      end

      // reset while waiting for dist_calc
      req       = 4'b0100;
      stub_busy = 10;
      @(negedge clk);
      check("t3_gnt", gnt, 4'b0100);
      req = '0;
      @(negedge clk);
      repeat (4) @(negedge clk);
      do_reset();
      bad = 0;
      repeat (15) begin
         @(negedge clk);
         if (rsp_valid) bad++;
      end
      check("t3_no_rsp", bad, 0);
      req = 4'b1111;
      serve(2, rand_d2(), 2);

      // dist_calc never finishes
      prev_d2    = rsp_dist2;
      stub_never = 1'b1;
      req[1]     = 1'b1;
      @(negedge clk);
      check("t6_gnt", gnt, N'(1) << model_pick(4'b0010, model_ptr));
      req = '0;
      @(negedge clk);
      check("t6_calc_ready", calc_ready, 1);
      cnt      = 0;
      lat      = 0;
      err_seen = 1'b0;
      for (int i = 1; i <= TO + 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            cnt++;
            if (cnt == 1) begin
               lat      = i;
               err_seen = rsp_err;
            end
         end
      end
`ifdef DIST_ARB_TIMEOUT_EN
      check("t6_rsp_count", cnt, 1);
      check("t6_rsp_lat", lat, TO);
      check("t6_rsp_err", err_seen, 1);
      check("t6_dist2_kept", rsp_dist2, prev_d2);
`else
      check("t6_no_rsp", cnt, 0);
      check("t6_err_low", rsp_err, 0);
      check("t6_dist2_kept", rsp_dist2, prev_d2);
`endif
      $display("txn: watchdog scenario, %0d responses, latency %0d", cnt, lat);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
